// File: rtl/smultadd_acc.sv
// rtl/smultadd_acc.sv - pipelined signed sum-of-products engine with frame accumulator
//
// Purpose:
//   NCH lanes of signed DWIDTH x DWIDTH products are summed by a registered
//   adder tree. The tree sum is either delivered per beat or accumulated
//   over a frame that ends on in_last.
//
// Ports:
//   clk       clock
//   sclr_n    synchronous active-low reset (priority over ena)
//   ena       global clock enable, freezes every register when 0
//   in_vld    input beat valid
//   in_last   last beat of frame (accumulate mode only)
//   acc_mode  0 = per-beat sum, 1 = accumulate until in_last
//   da, db    packed signed lane operands, lane i at [i*DWIDTH +: DWIDTH]
//   out_vld   result valid
//   out       signed result, OW = 2*DWIDTH + $clog2(NCH) + AWIDTH bits
//   ovf       signed overflow occurred in the delivered result
module smultadd_acc #(
  parameter int DWIDTH = 16,
  parameter int NCH    = 4,
  parameter int AWIDTH = 8,
  localparam int LOG   = $clog2(NCH),
  localparam int SW    = 2 * DWIDTH + LOG,
  localparam int OW    = SW + AWIDTH
) (
  input  logic                     clk,
  input  logic                     sclr_n,
  input  logic                     ena,
  input  logic                     in_vld,
  input  logic                     in_last,
  input  logic                     acc_mode,
  input  logic [NCH*DWIDTH-1:0]    da,
  input  logic [NCH*DWIDTH-1:0]    db,
  output logic                     out_vld,
  output logic signed [OW-1:0]     out,
  output logic                     ovf
);

  // Number of live nodes at a given tree level (level 0 = products).
  function automatic int nodes_at(input int lvl);
    int n;
    n = NCH;
    for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
    return n;
  endfunction

  // Stage 0: registered operands.
  logic signed [DWIDTH-1:0] a_q [NCH];
  logic signed [DWIDTH-1:0] a_d [NCH];
  logic signed [DWIDTH-1:0] b_q [NCH];
  logic signed [DWIDTH-1:0] b_d [NCH];

  // Beat tags: index 0 = stage 0, 1 = products, 2..LOG+1 = tree levels.
  logic vld_q  [LOG+2];
  logic vld_d  [LOG+2];
  logic last_q [LOG+2];
  logic last_d [LOG+2];
  logic mode_q [LOG+2];
  logic mode_d [LOG+2];

  // Tree nodes: level 0 holds products, level LOG holds the final sum in
  // node 0. Every node is kept at SW bits; a node at level l needs only
  // 2*DWIDTH+l bits, so the sign-extended arithmetic is exact throughout.
  // One spare column keeps the pairwise reads in range for odd counts.
  logic signed [SW-1:0] tree_q [LOG+1][NCH+1];
  logic signed [SW-1:0] tree_d [LOG+1][NCH+1];

  // Output / accumulator stage.
  logic signed [OW-1:0] acc_q, acc_d;
  logic                 sticky_q, sticky_d;
  logic signed [OW-1:0] out_q, out_d;
  logic                 out_vld_q, out_vld_d;
  logic                 ovf_q, ovf_d;

  logic signed [OW-1:0] sum_ext;
  logic signed [OW-1:0] acc_sum;
  logic                 add_ovf;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      a_d[i] = da[i*DWIDTH +: DWIDTH];
      b_d[i] = db[i*DWIDTH +: DWIDTH];
    end

    vld_d[0]  = in_vld;
    last_d[0] = in_last;
    mode_d[0] = acc_mode;
    for (int t = 1; t < LOG + 2; t++) begin
      vld_d[t]  = vld_q[t-1];
      last_d[t] = last_q[t-1];
      mode_d[t] = mode_q[t-1];
    end

    for (int l = 0; l <= LOG; l++) begin
      for (int j = 0; j <= NCH; j++) begin
        tree_d[l][j] = '0;
      end
    end

    // Products are formed at SW bits so the multiply itself is exact.
    for (int i = 0; i < NCH; i++) begin
      tree_d[0][i] = SW'(a_q[i] * b_q[i]);
    end

    for (int l = 1; l <= LOG; l++) begin
      for (int j = 0; j < (NCH + 1) / 2; j++) begin
        if (j < nodes_at(l)) begin
          if (2 * j + 1 < nodes_at(l - 1)) begin
            tree_d[l][j] = tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
          end else begin
            // Odd leftover node passes through unchanged.
            tree_d[l][j] = tree_q[l-1][2*j];
          end
        end
      end
    end
  end

  always_comb begin
    sum_ext   = OW'(tree_q[LOG][0]);
    acc_sum   = acc_q + sum_ext;
    // Two's-complement overflow: operands agree in sign, result does not.
    add_ovf   = (acc_q[OW-1] == sum_ext[OW-1]) && (acc_sum[OW-1] != acc_q[OW-1]);

    acc_d     = acc_q;
    sticky_d  = sticky_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    out_vld_d = 1'b0;

    if (vld_q[LOG+1]) begin
      if (!mode_q[LOG+1]) begin
        // Per-beat result; any pending partial frame is discarded.
        out_d     = sum_ext;
        ovf_d     = 1'b0;
        out_vld_d = 1'b1;
        acc_d     = '0;
        sticky_d  = 1'b0;
      end else if (last_q[LOG+1]) begin
        out_d     = acc_sum;
        ovf_d     = sticky_q | add_ovf;
        out_vld_d = 1'b1;
        acc_d     = '0;
        sticky_d  = 1'b0;
      end else begin
        acc_d     = acc_sum;
        sticky_d  = sticky_q | add_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      for (int i = 0; i < NCH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      for (int t = 0; t < LOG + 2; t++) begin
        vld_q[t]  <= 1'b0;
        last_q[t] <= 1'b0;
        mode_q[t] <= 1'b0;
      end
      for (int l = 0; l <= LOG; l++) begin
        for (int j = 0; j <= NCH; j++) begin
          tree_q[l][j] <= '0;
        end
      end
      acc_q     <= '0;
      sticky_q  <= 1'b0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (ena) begin
      for (int i = 0; i < NCH; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
      end
      for (int t = 0; t < LOG + 2; t++) begin
        vld_q[t]  <= vld_d[t];
        last_q[t] <= last_d[t];
        mode_q[t] <= mode_d[t];
      end
      for (int l = 0; l <= LOG; l++) begin
        for (int j = 0; j <= NCH; j++) begin
          tree_q[l][j] <= tree_d[l][j];
        end
      end
      acc_q     <= acc_d;
      sticky_q  <= sticky_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out     = out_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_smultadd_acc.sv
// tb/tb_smultadd_acc.sv - self-checking bench for smultadd_acc (AWIDTH=8 and AWIDTH=1 instances)
module tb_smultadd_acc;

  localparam int DW  = 16;
  localparam int NC  = 4;
  localparam int OW8 = 2 * DW + 2 + 8;
  localparam int OW1 = 2 * DW + 2 + 1;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic sclr_n, ena, in_vld, in_last, acc_mode;
  logic [NC*DW-1:0] da, db;
  logic out_vld8, ovf8, out_vld1, ovf1;
  logic signed [OW8-1:0] out8;
  logic signed [OW1-1:0] out1;

  always #5 clk = ~clk;

  smultadd_acc #(.DWIDTH(DW), .NCH(NC), .AWIDTH(8)) dut8 (
    .clk(clk), .sclr_n(sclr_n), .ena(ena), .in_vld(in_vld), .in_last(in_last),
    .acc_mode(acc_mode), .da(da), .db(db), .out_vld(out_vld8), .out(out8), .ovf(ovf8)
  );

  smultadd_acc #(.DWIDTH(DW), .NCH(NC), .AWIDTH(1)) dut1 (
    .clk(clk), .sclr_n(sclr_n), .ena(ena), .in_vld(in_vld), .in_last(in_last),
    .acc_mode(acc_mode), .da(da), .db(db), .out_vld(out_vld1), .out(out1), .ovf(ovf1)
  );

  int checks = 0;
  int errors = 0;

  // Lane operands as plain integers.
  int la [NC];
  int lb [NC];

  // Reference model: frame state per instance plus a latency line of results.
  longint acc_m  [2];
  bit     st_m   [2];
  bit     dl_v   [LAT];
  longint dl_o   [2][LAT];
  bit     dl_f   [2][LAT];
  longint last_o [2];
  bit     last_f [2];

  function automatic longint wrap(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_lanes(input int a0, a1, a2, a3, b0, b1, b2, b3);
    la[0] = a0; la[1] = a1; la[2] = a2; la[3] = a3;
    lb[0] = b0; lb[1] = b1; lb[2] = b2; lb[3] = b3;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      acc_m[k] = 0; st_m[k] = 0; last_o[k] = 0; last_f[k] = 0;
      for (int i = 0; i < LAT; i++) begin
        dl_o[k][i] = 0; dl_f[k][i] = 0;
      end
    end
    for (int i = 0; i < LAT; i++) dl_v[i] = 0;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input bit v, input bit l, input bit m, input bit e, input bit r);
    longint s, ex, w;
    bit     nv;
    longint no [2];
    bit     nf [2];
    int     wd;
    in_vld = v; in_last = l; acc_mode = m; ena = e; sclr_n = r;
    for (int i = 0; i < NC; i++) begin
      da[i*DW +: DW] = la[i][DW-1:0];
      db[i*DW +: DW] = lb[i][DW-1:0];
    end
    s = 0;
    for (int i = 0; i < NC; i++) s += longint'(la[i]) * longint'(lb[i]);
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else if (e) begin
      nv = 0;
      for (int k = 0; k < 2; k++) begin
        wd = (k == 0) ? OW8 : OW1;
        no[k] = 0; nf[k] = 0;
        if (v) begin
          if (!m) begin
            nv = 1; no[k] = wrap(s, wd); nf[k] = 0;
            acc_m[k] = 0; st_m[k] = 0;
          end else begin
            ex = acc_m[k] + s;
            w  = wrap(ex, wd);
            if (l) begin
              nv = 1; no[k] = w; nf[k] = st_m[k] | (w != ex);
              acc_m[k] = 0; st_m[k] = 0;
            end else begin
              acc_m[k] = w; st_m[k] = st_m[k] | (w != ex);
            end
          end
        end
      end
      for (int i = LAT - 1; i > 0; i--) begin
        dl_v[i] = dl_v[i-1];
        for (int k = 0; k < 2; k++) begin
          dl_o[k][i] = dl_o[k][i-1]; dl_f[k][i] = dl_f[k][i-1];
        end
      end
      dl_v[0] = nv;
      for (int k = 0; k < 2; k++) begin
        dl_o[k][0] = no[k]; dl_f[k][0] = nf[k];
        if (dl_v[LAT-1]) begin
          last_o[k] = dl_o[k][LAT-1]; last_f[k] = dl_f[k][LAT-1];
        end
      end
    end
    #1;
    check("vld8", longint'(out_vld8), longint'(dl_v[LAT-1]));
    check("out8", longint'(out8), last_o[0]);
    check("ovf8", longint'(ovf8), longint'(last_f[0]));
    check("vld1", longint'(out_vld1), longint'(dl_v[LAT-1]));
    check("out1", longint'(out1), last_o[1]);
    check("ovf1", longint'(ovf1), longint'(last_f[1]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 1);
  endtask

  initial begin
    logic signed [DW-1:0] t;
    model_reset();
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    sclr_n = 0; ena = 1; in_vld = 0; in_last = 0; acc_mode = 0; da = '0; db = '0;

    // Reset state.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("rst_out", longint'(out8), 0);
    check("rst_vld", longint'(out_vld8), 0);
    check("rst_ovf", longint'(ovf8), 0);

    // Per-beat sum of the 70-vector, five cycles of latency.
    set_lanes(1, 2, 3, 4, 5, 6, 7, 8);
    step(1, 0, 0, 1, 1);
    idle(3);
    check("pb_early_vld", longint'(out_vld8), 0);
    idle(1);
    check("pb_vld", longint'(out_vld8), 1);
    check("pb_out", longint'(out8), 70);
    check("pb_ovf", longint'(ovf8), 0);
    idle(1);
    check("pb_vld_drop", longint'(out_vld8), 0);

    // Corner products.
    set_lanes(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    step(1, 0, 0, 1, 1);
    set_lanes(-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767);
    step(1, 0, 0, 1, 1);
    idle(3);
    check("corner_max", longint'(out8), 64'sd4294967296);
    check("corner_max1", longint'(out1), 64'sd4294967296);
    idle(1);
    check("corner_mix", longint'(out8), -64'sd4294836224);

    // Three-beat frame.
    set_lanes(1, 2, 3, 4, 5, 6, 7, 8);
    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    idle(4);
    check("acc_vld", longint'(out_vld8), 1);
    check("acc_out", longint'(out8), 210);

    // Overflow in the narrow accumulator only.
    set_lanes(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    idle(4);
    check("ovf_out1", longint'(out1), -64'sd17179869184);
    check("ovf_flag1", longint'(ovf1), 1);
    check("ovf_out8", longint'(out8), 64'sd17179869184);
    check("ovf_flag8", longint'(ovf8), 0);
    step(1, 1, 1, 1, 1);
    idle(4);
    check("single_ovf1", longint'(ovf1), 0);
    check("single_out1", longint'(out1), 64'sd4294967296);

    // Stall for three cycles mid-pipeline.
    set_lanes(2, 2, 2, 2, 3, 3, 3, 3);
    step(1, 0, 0, 1, 1);
    idle(1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    idle(2);
    check("stall_early", longint'(out_vld8), 0);
    idle(1);
    check("stall_vld", longint'(out_vld8), 1);
    check("stall_out", longint'(out8), 24);

    // Partial frame aborted by a per-beat sum.
    set_lanes(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 1);
    set_lanes(1, 2, 3, 4, 5, 6, 7, 8);
    step(1, 0, 0, 1, 1);
    idle(4);
    check("abort_out", longint'(out8), 70);
    check("abort_ovf", longint'(ovf1), 0);

    // Reset during a partial frame.
    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 1);
    step(0, 0, 0, 1, 0);
    idle(6);
    check("rst_mid_out", longint'(out8), 0);
    check("rst_mid_vld", longint'(out_vld8), 0);
    set_lanes(1, 1, 1, 1, 1, 2, 3, 4);
    step(1, 1, 1, 1, 1);
    idle(4);
    check("post_rst_out", longint'(out8), 10);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          la[i] = -32768; lb[i] = ($urandom_range(0, 1) == 1) ? -32768 : 32767;
        end else begin
          t = DW'($urandom); la[i] = t;
          t = DW'($urandom); lb[i] = t;
        end
      end
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 6) != 0),
           1'($urandom_range(0, 99) != 0));
    end
    idle(LAT + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
